// File: rtl/gf256_sweep_scheduler.sv
// Two-client round-robin scheduler sharing one mod-2^W down-counting index generator.
// A granted sweep streams len+1 indices from start downward, wrapping 0 -> 2^W-1.
module gf256_sweep_scheduler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] start0,
  input  logic [W-1:0] start1,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
  input  logic         hold,
  output logic         gnt0,
  output logic         gnt1,
  output logic [W-1:0] idx_out,
  output logic         idx_valid,
  output logic         idx_owner,
  output logic         done0,
  output logic         done1,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_rem;
  logic         r_owner;
  logic         r_ptr;
  logic         r_gnt0;
  logic         r_gnt1;
  logic         r_done0;
  logic         r_done1;

  state_t       w_state_nxt;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] w_rem_nxt;
  logic         w_owner_nxt;
  logic         w_ptr_nxt;
  logic         w_gnt0_nxt;
  logic         w_gnt1_nxt;
  logic         w_done0_nxt;
  logic         w_done1_nxt;
  logic         w_winner;

  // On a tie the client that did not win last time is picked.
  assign w_winner = (req0 && req1) ? ~r_ptr : req1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_cnt_nxt   = w_winner ? start1 : start0;
          w_rem_nxt   = w_winner ? len1 : len0;
          w_owner_nxt = w_winner;
          w_ptr_nxt   = w_winner;
          w_gnt0_nxt  = ~w_winner;
          w_gnt1_nxt  = w_winner;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!hold) begin
          if (r_rem == '0) begin
            w_state_nxt = S_GAP;
            w_done0_nxt = ~r_owner;
            w_done1_nxt = r_owner;
          end else begin
            // Plain modulo-2^W subtraction gives the 0 -> 2^W-1 wrap.
            w_cnt_nxt = r_cnt - W'(1);
            w_rem_nxt = r_rem - W'(1);
          end
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_owner <= 1'b0;
      r_ptr   <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign idx_out   = r_cnt;
  assign idx_owner = r_owner;
  assign idx_valid = (r_state == S_RUN) && !hold;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gf256_sweep_scheduler.sv
// Directed bench for gf256_sweep_scheduler: expected {owner, index} pairs are queued
// when a sweep is requested and popped by a monitor whenever idx_valid is seen.
module tb_gf256_sweep_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] start0, start1, len0, len1;
  logic       hold;
  logic       gnt0, gnt1, idx_valid, idx_owner, done0, done1, busy;
  logic [7:0] idx_out;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  gf256_sweep_scheduler #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .start0(start0), .start1(start1),
    .len0(len0), .len1(len1),
    .hold(hold),
    .gnt0(gnt0), .gnt1(gnt1),
    .idx_out(idx_out), .idx_valid(idx_valid), .idx_owner(idx_owner),
    .done0(done0), .done1(done1), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic gnt_of(input bit c);
    return c ? gnt1 : gnt0;
  endfunction

  function automatic logic done_of(input bit c);
    return c ? done1 : done0;
  endfunction

  // Scoreboard monitor: every valid element must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && idx_valid) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_idx: observed %0h with no expected element", idx_out);
      end
      if (exp_q.size() != 0) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("idx_stream", {23'd0, idx_owner, idx_out}, {23'd0, e});
      end
    end
  end

  // Requests one sweep from an idle DUT, checks the grant, valid count and done pulse.
  task automatic sweep(input bit c, input logic [7:0] st, input logic [7:0] ln);
    int t;
    int nv;
    if (c) begin req1 = 1'b1; start1 = st; len1 = ln; end
    else   begin req0 = 1'b1; start0 = st; len0 = ln; end
    for (int k = 0; k <= int'(ln); k++) exp_q.push_back({c, st - 8'(k)});
    t = 0;
    do begin @(negedge clk); t++; end while (gnt_of(c) !== 1'b1 && t < 20);
    check("gnt", {31'd0, gnt_of(c)}, 1);
    check("gnt_other", {31'd0, gnt_of(~c)}, 0);
    if (c) req1 = 1'b0; else req0 = 1'b0;
    nv = 0;
    t  = 0;
    while (done_of(c) !== 1'b1 && t < 400) begin
      if (idx_valid) nv++;
      @(negedge clk);
      t++;
    end
    check("done", {31'd0, done_of(c)}, 1);
    check("done_other", {31'd0, done_of(~c)}, 0);
    check("gap_invalid", {31'd0, idx_valid}, 0);
    check("nvalid", nv, int'(ln) + 1);
  endtask

  initial begin
    int t, nv, ng, last_v;
    bit exp_w;

    // ---- reset with random inputs ----
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
    start0 = '0; start1 = '0; len0 = '0; len1 = '0;
    #1;
    rst_n  = 1'b0;
    req0   = 1'($urandom); req1 = 1'($urandom); hold = 1'b1;
    start0 = 8'($urandom); start1 = 8'($urandom);
    len0   = 8'($urandom); len1 = 8'($urandom);
    #1;
    check("rst_outputs", {20'd0, gnt0, gnt1, done0, done1, idx_valid, busy, idx_owner, 1'b0, idx_out}, 0);
    repeat (2) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 0);
    end

    // ---- basic sweep: 5,4,3,2 ----
    sweep(1'b0, 8'd5, 8'd3);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 0);

    // ---- wrap: 1,0,255,254 owned by client 1 ----
    sweep(1'b1, 8'd1, 8'd3);
    @(negedge clk);

    // ---- full length: 0,255,...,1 ----
    sweep(1'b0, 8'd0, 8'd255);
    @(negedge clk);

    // ---- arbitration from reset, both requesting, len=0 ----
    rst_n = 1'b0;
    #1;
    req0 = 1'b1; start0 = 8'h11; len0 = 8'd0;
    req1 = 1'b1; start1 = 8'h22; len1 = 8'd0;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    @(negedge clk);
    rst_n = 1'b1;
    ng = 0; exp_w = 1'b0; last_v = -1;
    for (int cy = 0; cy < 60; cy++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        check("arb_gnt", {30'd0, gnt1, gnt0}, exp_w ? 2 : 1);
        if (exp_w) req1 = 1'b0; else req0 = 1'b0;
        exp_w = ~exp_w;
        ng++;
      end
      if (idx_valid) begin
        if (last_v >= 0) check("arb_gap", cy - last_v - 1, 2);
        last_v = cy;
      end
      if (done0 && ng <= 2) req0 = 1'b1;
      if (done1 && ng <= 2) req1 = 1'b1;
      if ((done0 || done1) && ng == 4) break;
    end
    check("arb_grants", ng, 4);
    @(negedge clk);
    check("arb_idle", {31'd0, busy}, 0);

    // ---- hold: 10,9 then 3 stalled cycles on 8, then 8,7,6 ----
    req0 = 1'b1; start0 = 8'd10; len0 = 8'd4;
    for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 8'd10 - 8'(k)});
    nv = 0;
    @(negedge clk);
    check("hold_gnt", {31'd0, gnt0}, 1);
    if (idx_valid) nv++;
    req0 = 1'b0;
    @(negedge clk);
    if (idx_valid) nv++;
    @(posedge clk); #1;
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_idx", {24'd0, idx_out}, 8);
      check("hold_valid", {31'd0, idx_valid}, 0);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      if (idx_valid) nv++;
      t++;
    end while (done0 !== 1'b1 && t < 20);
    check("hold_done", {31'd0, done0}, 1);
    check("hold_nvalid", nv, 5);
    @(negedge clk);

    // ---- reset mid-sweep at idx 200, then regrant from start0 ----
    req0 = 1'b1; start0 = 8'd205; len0 = 8'd20;
    for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, 8'd205 - 8'(k)});
    t = 0;
    do begin @(negedge clk); t++; end while (gnt0 !== 1'b1 && t < 20);
    req0 = 1'b0;
    t = 0;
    while (!(idx_valid && idx_out == 8'd200) && t < 20) begin @(negedge clk); t++; end
    #2;
    check("abort_idx", {24'd0, idx_out}, 200);
    check("abort_q_drained", exp_q.size(), 0);
    rst_n = 1'b0;
    req0 = 1'b1; start0 = 8'd205; len0 = 8'd2;
    hold = 1'($urandom); start1 = 8'($urandom); len1 = 8'($urandom);
    #1;
    check("abort_outputs", {20'd0, gnt0, gnt1, done0, done1, idx_valid, busy, idx_owner, 1'b0, idx_out}, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", {30'd0, done0, busy}, 0);
    end
    hold = 1'b0;
    rst_n = 1'b1;
    sweep(1'b0, 8'd205, 8'd2);
    @(negedge clk);
    check("final_idle", {31'd0, busy}, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
